// File: rtl/df_mid_tdatq_pick13.sv
// Pick stage behind the df_mid_tdatq_q13 queue. It captures the entry the age matrix marks
// oldest, buffers it in a 2-entry skid FIFO and issues it over a valid/ready handshake.
module df_mid_tdatq_pick13 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IXW   = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [DEPTH-1:0]       Valid,
  input  logic [DEPTH-1:0]       Oldest,
  input  logic [DEPTH*WIDTH-1:0] QVect,
  input  logic                   Flush,
  input  logic                   IssRdy,
  output logic                   IssVld,
  output logic [WIDTH-1:0]       IssPkt,
  output logic [IXW-1:0]         IssIx,
  output logic [DEPTH-1:0]       DelValid,
  output logic [DEPTH-1:0]       Pickable,
  output logic                   ErrMultiHot
);

  logic [WIDTH-1:0] pkt_q [2];
  logic [WIDTH-1:0] pkt_d [2];
  logic [IXW-1:0]   ix_q  [2];
  logic [IXW-1:0]   ix_d  [2];
  logic             head_q, head_d;
  logic [1:0]       count_q, count_d;
  logic [DEPTH-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic             pop;
  logic             capture;
  logic             space;
  logic             multi_hot;
  logic             one_hot;
  logic             tail;
  logic [IXW-1:0]   pick_ix;
  logic [WIDTH-1:0] pick_pkt;

  assign multi_hot = (Oldest & (Oldest - DEPTH'(1))) != '0;
  assign one_hot   = (Oldest != '0) && !multi_hot;
  assign space     = (count_q < 2'd2) || pop;
  assign capture   = one_hot && ((Oldest & Valid & ~inflight_q) != '0) && space && !Flush;
  // With count=2 the tail wraps onto the head slot, which a simultaneous pop frees.
  assign tail      = head_q ^ count_q[0];

  always_comb begin
    pick_ix  = '0;
    pick_pkt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Oldest[i]) begin
        pick_ix  = IXW'(i);
        pick_pkt = QVect[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    IssVld = (count_q != 2'd0);
    IssPkt = IssVld ? pkt_q[head_q] : '0;
    IssIx  = IssVld ? ix_q[head_q]  : '0;
    pop    = IssVld && IssRdy && !Flush;
    DelValid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pop && (IXW'(i) == IssIx)) DelValid[i] = 1'b1;
    end
    Pickable    = Reset ? '0 : (Valid & ~inflight_q);
    ErrMultiHot = err_q;
  end

  always_comb begin
    pkt_d      = pkt_q;
    ix_d       = ix_q;
    head_d     = head_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q | multi_hot;
    if (Flush) begin
      head_d     = 1'b0;
      count_d    = 2'd0;
      inflight_d = '0;
    end else begin
      // Entries deleted externally drop out of InFlight; their FIFO copy still issues.
      inflight_d = (inflight_q & Valid) & ~DelValid;
      if (pop) head_d = ~head_q;
      if (capture) begin
        pkt_d[tail] = pick_pkt;
        ix_d[tail]  = pick_ix;
        inflight_d  = inflight_d | Oldest;
      end
      count_d = count_q + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pkt_q[0]   <= '0;
      pkt_q[1]   <= '0;
      ix_q[0]    <= '0;
      ix_q[1]    <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pkt_q      <= pkt_d;
      ix_q       <= ix_d;
      head_q     <= head_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_df_mid_tdatq_pick13.sv
// Directed bench for df_mid_tdatq_pick13: issue, backpressure, full pop+push, flush,
// multi-hot error and reset mid-operation, with hand-computed expectations.
module tb_df_mid_tdatq_pick13;

  logic        Clk;
  logic        Reset;
  logic [3:0]  Valid;
  logic [3:0]  Oldest;
  logic [15:0] QVect;
  logic        Flush;
  logic        IssRdy;
  logic        IssVld;
  logic [3:0]  IssPkt;
  logic [1:0]  IssIx;
  logic [3:0]  DelValid;
  logic [3:0]  Pickable;
  logic        ErrMultiHot;

  int total = 0;
  int bad   = 0;

  df_mid_tdatq_pick13 #(.WIDTH(4), .DEPTH(4), .IXW(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Valid       (Valid),
    .Oldest      (Oldest),
    .QVect       (QVect),
    .Flush       (Flush),
    .IssRdy      (IssRdy),
    .IssVld      (IssVld),
    .IssPkt      (IssPkt),
    .IssIx       (IssIx),
    .DelValid    (DelValid),
    .Pickable    (Pickable),
    .ErrMultiHot (ErrMultiHot)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later, well clear of the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    Reset = 1'b1; Valid = 4'b1111; Oldest = '0; QVect = '0; Flush = 1'b0; IssRdy = 1'b0;
    settle();
    check("rst_pickable_forced0", Pickable, 4'b0000);
    tick(); tick();
    Reset = 1'b0;
    settle();
    check("rst_issvld", IssVld, 0);
    check("rst_isspkt", IssPkt, 0);
    check("rst_issix", IssIx, 0);
    check("rst_delvalid", DelValid, 0);
    check("rst_err", ErrMultiHot, 0);
    check("rst_pickable", Pickable, 4'b1111);

    // 1. Basic issue
    Valid = 4'b0011; Oldest = 4'b0001; QVect = 16'h00A5; IssRdy = 1'b1;
    settle();
    check("t1_no_same_cycle", IssVld, 0);
    tick();
    Oldest = '0;
    settle();
    check("t1_vld", IssVld, 1);
    check("t1_pkt", IssPkt, 4'h5);
    check("t1_ix", IssIx, 0);
    check("t1_del", DelValid, 4'b0001);
    check("t1_pickable", Pickable, 4'b0010);
    tick();
    check("t1_empty", IssVld, 0);
    check("t1_pickable_after", Pickable, 4'b0011);

    // 2. Backpressure
    IssRdy = 1'b0; Valid = 4'b0111; QVect = 16'h0CA5;
    Oldest = 4'b0001; tick();
    Oldest = 4'b0010;
    settle();
    check("t2_hold_pkt_a", IssPkt, 4'h5);
    check("t2_no_del", DelValid, 0);
    tick();
    Oldest = 4'b0100; tick();
    Oldest = '0;
    settle();
    check("t2_pickable", Pickable, 4'b0100);
    check("t2_hold_pkt_b", IssPkt, 4'h5);
    tick();
    check("t2_hold_pkt_c", IssPkt, 4'h5);
    IssRdy = 1'b1; Oldest = 4'b0100;
    settle();
    check("t2_del0", DelValid, 4'b0001);
    tick();
    Oldest = '0;
    settle();
    check("t2_pkt1", IssPkt, 4'hA);
    check("t2_ix1", IssIx, 1);
    check("t2_del1", DelValid, 4'b0010);
    tick();
    check("t2_pkt2", IssPkt, 4'hC);
    check("t2_ix2", IssIx, 2);
    check("t2_del2", DelValid, 4'b0100);
    tick();
    check("t2_drained", IssVld, 0);
    check("t2_pickable_end", Pickable, 4'b0111);

    // 3. Pop plus push at full
    IssRdy = 1'b0; Valid = 4'b1011; QVect = 16'h7CA5;
    Oldest = 4'b0001; tick();
    Oldest = 4'b0010; tick();
    IssRdy = 1'b1; Oldest = 4'b1000;
    settle();
    check("t3_del_head", DelValid, 4'b0001);
    tick();
    Oldest = '0;
    settle();
    check("t3_pkt_a", IssPkt, 4'hA);
    check("t3_del_a", DelValid, 4'b0010);
    tick();
    check("t3_vld_3", IssVld, 1);
    check("t3_pkt_3", IssPkt, 4'h7);
    check("t3_ix_3", IssIx, 3);
    check("t3_del_3", DelValid, 4'b1000);
    tick();
    check("t3_drained", IssVld, 0);

    // 4. Flush
    IssRdy = 1'b0; Valid = 4'b0011; QVect = 16'h00A5;
    Oldest = 4'b0001; tick();
    Oldest = 4'b0010; tick();
    Oldest = '0; IssRdy = 1'b1; Flush = 1'b1;
    settle();
    check("t4_del_flush", DelValid, 0);
    check("t4_pickable_inflight", Pickable, 4'b0000);
    tick();
    Flush = 1'b0;
    settle();
    check("t4_vld", IssVld, 0);
    check("t4_pickable", Pickable, 4'b0011);

    // 5. Multi-hot
    Oldest = 4'b0011; tick();
    Oldest = '0;
    settle();
    check("t5_no_capture", IssVld, 0);
    check("t5_err", ErrMultiHot, 1);
    Oldest = 4'b0010; tick();
    Oldest = '0;
    settle();
    check("t5_pkt", IssPkt, 4'hA);
    check("t5_err_sticky", ErrMultiHot, 1);
    tick();
    check("t5_err_sticky2", ErrMultiHot, 1);

    // 6. Reset mid-operation
    IssRdy = 1'b0;
    Oldest = 4'b0001; tick();
    Oldest = 4'b0010; tick();
    Oldest = '0; Reset = 1'b1;
    settle();
    check("t6_pickable_rst", Pickable, 0);
    check("t6_vld_before", IssVld, 1);
    tick();
    Reset = 1'b0; IssRdy = 1'b1;
    settle();
    check("t6_vld", IssVld, 0);
    check("t6_pkt", IssPkt, 0);
    check("t6_ix", IssIx, 0);
    check("t6_del", DelValid, 0);
    check("t6_err", ErrMultiHot, 0);
    check("t6_inflight", Pickable, 4'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
